vcard_pix: RTL and testbench
============================

Name: vcard_pix

Overview:
- Parametrised successor of the 640x400 packed-pixel video card.
- Scans a 320x200 logical framebuffer, line- and pixel-doubled, in selectable 1/2/4 bpp packing.
- Colours come from a writable 16x12-bit palette; a frame-latched base address gives vertical scroll.
- Sits between the CPU-writable video RAM (synchronous read, 1-clock latency) and the 12-bit VGA DAC pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, front porch clocks
H_SYNC, 96, hsync clocks
H_BACK, 48, back porch clocks
V_VISIBLE, 400, visible lines
V_FRONT, 12, front porch lines
V_SYNC, 2, vsync lines
V_BACK, 35, back porch lines
ADDR_W, 15, video RAM address width

Ports:
clock  in  1  pixel clock (25 MHz class)
reset_n  in  1  asynchronous active-low reset
r  out  4  red
g  out  4  green
b  out  4  blue
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active high
address  out  ADDR_W  video RAM read address
data  in  8  video RAM read data, valid 1 clock after address
mode  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=reserved (treated as 2bpp)
base  in  ADDR_W  framebuffer start address
pal_we  in  1  palette write strobe
pal_idx  in  4  palette entry
pal_data  in  12  palette value {r,g,b}
irq  out  1  vblank pulse (see Optional Feature)

Behaviour:
- Clock and reset: single clock domain `clock`; reset_n is asynchronous, active low.
- Reset values: x=0, y=0, r/g/b=0, hs=1, vs=0, address=0, irq=0, mode_q=1, base_q=0.
- Palette reset values: 0=111, 1=C0C, 2=0CC, 3=CCC; entries 4..15 = 000.
- Line layout: [back][visible][front][sync]; H_WHOLE = sum of the four horizontal parameters. Frame layout is identical, using lines.
- Counters: x wraps at H_WHOLE-1 and advances y; y wraps at V_WHOLE-1. Define X = x-H_BACK and Y = y-V_BACK.
- Frame latch: mode_q and base_q sample mode/base only on the clock where x=0 and y=0. Changes mid-frame take effect next frame.
- Clocks per byte: P = 16 / 8 / 4 for 1 / 2 / 4 bpp.
- Row stride: S = 40 / 80 / 160 bytes.
- row_base:
  - Loaded with base_q at y=0.
  - Gains S at xmax of every visible line with Y[0]=1, so each logical row is shown twice.
- Fetch timing: address = row_base + k for byte k, issued on the clock where X = P*k-2. The final fetch is at k = S-1.
- Load timing: data is loaded into pixel shift register sr on the clock where X = P*k-1.
- Pixel order: LSB-first. Leftmost pixel is data[bpp-1:0]; each pixel lasts 2 clocks.
- Pixel index: palette index is the low bpp bits of sr, zero-extended.
- Arithmetic: all address math is modulo 2^ADDR_W, so wrap-around is silent.
- Output pipeline:
  - rgb, hs and vs are registered, one clock behind the counters.
  - rgb equals palette[idx] when shown, else 000.
- Palette writes:
  - A write on clock t is visible in rgb from the pixel computed at t+1. There is no tearing protection.
  - A write to the same entry being displayed on that clock shows the old value for that clock.
- Reset mid-frame: all state returns to reset values immediately; scanning restarts at x=y=0.

Optional Feature:
- Macro: VCARD_IRQ_EN.
- When defined: irq pulses high for exactly 1 clock on the first clock of line V_BACK+V_VISIBLE (x=0), i.e. start of front porch.
- When undefined: irq is constant 0 and the pulse logic is absent.

Decomposition:
- Package vcard_pkg:
  - Mode encodings (MODE_1BPP, MODE_2BPP, MODE_4BPP).
  - Per-mode P and S constants.
  - Default palette array.
  - Default 640x400 timing constants.
- Sub-module vcard_timing:
  - Holds the x/y counters, xmax/ymax, shown, X, Y.
  - Produces unregistered hs/vs and the frame-start strobe.
  - Parametrised by the eight timing parameters.

Test Plan:
- Reset, then release: hs=1, vs=0, rgb=000, address=0. After one frame (800x449 clocks) hs has 449 low pulses of 96 clocks, and vs is high for 2 lines.
- 2bpp, base=0, RAM[0]=E4: first 8 visible output clocks of line 0 are 111,111, C0C,C0C, 0CC,0CC, CCC,CCC.
- 1bpp, base=100: visible lines 0-1 fetch addresses 100..139; lines 2-3 start at address 140.
- 4bpp, base=2^15-10: address sequence on line 0 is 32758..32767, then 0..149.
- pal_we idx=1 data=F00 while displaying index 1: next output clock shows F00. Writing mode=2 mid-frame has no effect until after the next x=0,y=0.
- With VCARD_IRQ_EN: irq is high for exactly 1 clock per frame, at y=435, x=0. Without the macro, irq never rises.

Source files
------------

// File: rtl/vcard_pkg.sv
// vcard_pix shared types, per-mode constants and defaults.
// Optional vblank interrupt is enabled with VCARD_IRQ_EN.
package vcard_pkg;

  typedef enum logic [1:0] {
    MODE_1BPP = 2'd0,
    MODE_2BPP = 2'd1,
    MODE_4BPP = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 400;
  localparam int DEF_V_FRONT   = 12;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 35;

  // log2 of clocks per byte
  localparam logic [2:0] PSH_1BPP = 3'd4;
  localparam logic [2:0] PSH_2BPP = 3'd3;
  localparam logic [2:0] PSH_4BPP = 3'd2;

  // bytes per logical row
  localparam logic [7:0] S_1BPP = 8'd40;
  localparam logic [7:0] S_2BPP = 8'd80;
  localparam logic [7:0] S_4BPP = 8'd160;

  localparam logic [11:0] PAL_DEF [16] = '{
    12'h111, 12'hC0C, 12'h0CC, 12'hCCC,
    12'h000, 12'h000, 12'h000, 12'h000,
    12'h000, 12'h000, 12'h000, 12'h000,
    12'h000, 12'h000, 12'h000, 12'h000
  };

  function automatic logic [2:0] p_shift(input mode_e m);
    case (m)
      MODE_1BPP: return PSH_1BPP;
      MODE_4BPP: return PSH_4BPP;
      default:   return PSH_2BPP;
    endcase
  endfunction

  function automatic logic [7:0] stride(input mode_e m);
    case (m)
      MODE_1BPP: return S_1BPP;
      MODE_4BPP: return S_4BPP;
      default:   return S_2BPP;
    endcase
  endfunction

  function automatic logic [2:0] bpp_of(input mode_e m);
    case (m)
      MODE_1BPP: return 3'd1;
      MODE_4BPP: return 3'd4;
      default:   return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/vcard_timing.sv
// Raster counters, visibility and raw sync for vcard_pix.
// With VCARD_IRQ_EN a one-clock pulse marks start of front porch.
module vcard_timing import vcard_pkg::*; #(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int XW        = 10,
  parameter int YW        = 9
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [XW+1:0] xs,
  output logic          xmax,
  output logic          ytop,
  output logic          yodd,
  output logic          vvis,
  output logic          shown,
  output logic          fs,
  output logic          hs,
  output logic          vs,
  output logic          irq
);

  localparam int H_WHOLE = H_BACK + H_VISIBLE + H_FRONT + H_SYNC;
  localparam int V_WHOLE = V_BACK + V_VISIBLE + V_FRONT + V_SYNC;
  localparam int HS0 = H_BACK + H_VISIBLE + H_FRONT;
  localparam int VS0 = V_BACK + V_VISIBLE + V_FRONT;
  localparam logic VB0 = 1'(V_BACK % 2);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic ymax;
  logic hvis;

  assign xmax = x == XW'(H_WHOLE - 1);
  assign ymax = y == YW'(V_WHOLE - 1);

  // pixel and line counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (xmax) begin
      x <= '0;
      y <= ymax ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  assign xs    = (XW+2)'(x) - (XW+2)'(H_BACK);
  assign hvis  = x >= XW'(H_BACK)
              && x <  XW'(H_BACK + H_VISIBLE);
  assign vvis  = y >= YW'(V_BACK)
              && y <  YW'(V_BACK + V_VISIBLE);
  assign shown = hvis && vvis;
  assign ytop  = y == '0;
  assign fs    = ytop && x == '0;
  assign yodd  = y[0] ^ VB0;
  assign hs    = x <  XW'(HS0);
  assign vs    = y >= YW'(VS0);

`ifdef VCARD_IRQ_EN
  // pulse lands on x=0 of the first front-porch line
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else irq <= xmax
             && y == YW'(V_BACK + V_VISIBLE - 1);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: rtl/vcard_pix.sv
// Packed-pixel 320x200 scanout, line/pixel doubled, 1/2/4 bpp.
// Optional vblank pulse on irq is enabled with VCARD_IRQ_EN.
module vcard_pix import vcard_pkg::*; #(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int ADDR_W    = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              hs,
  output logic              vs,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        data,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_data,
  output logic              irq
);

  localparam int XW = $clog2(H_VISIBLE + H_FRONT
                           + H_SYNC + H_BACK);
  localparam int YW = $clog2(V_VISIBLE + V_FRONT
                           + V_SYNC + V_BACK);

  logic [XW+1:0] xs, t1, t3, k1, k3, pmask;
  logic xmax, ytop, yodd, vvis, shown, fs;
  logic hs_c, vs_c;
  mode_e mode_q;
  logic [ADDR_W-1:0] base_q, row_base, addr_q;
  logic [7:0] sr, s;
  logic [2:0] sh, nb;
  logic [3:0] idx;
  logic [11:0] pal [16];
  logic [11:0] rgb_q;
  logic hs_q, vs_q;
  logic fetch, load;

  vcard_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT),
    .H_SYNC(H_SYNC),       .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT),
    .V_SYNC(V_SYNC),       .V_BACK(V_BACK),
    .XW(XW),               .YW(YW)
  ) u_timing (
    .clock(clock), .reset_n(reset_n),
    .xs(xs), .xmax(xmax), .ytop(ytop),
    .yodd(yodd), .vvis(vvis), .shown(shown),
    .fs(fs), .hs(hs_c), .vs(vs_c), .irq(irq)
  );

  assign sh = p_shift(mode_q);
  assign s  = stride(mode_q);
  assign nb = bpp_of(mode_q);
  assign pmask = (XW+2)'((32'd1 << sh) - 32'd1);

  // address leads data by one clock, data leads sr by one
  assign t3 = xs + (XW+2)'(3);
  assign t1 = xs + (XW+2)'(1);
  assign k3 = t3 >> sh;
  assign k1 = t1 >> sh;
  assign fetch = vvis && (t3 & pmask) == '0
              && k3 < (XW+2)'(s);
  assign load  = vvis && (t1 & pmask) == '0
              && k1 < (XW+2)'(s);

  // mode and base only change at the top of a frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_2BPP;
      base_q <= '0;
    end else if (fs) begin
      mode_q <= mode_e'(mode);
      base_q <= base;
    end
  end

  // row base advances after every second visible line
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) row_base <= '0;
    else if (ytop) row_base <= base_q;
    else if (xmax && vvis && yodd)
      row_base <= row_base + ADDR_W'(s);
  end

  // byte fetch address register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else if (fetch) addr_q <= row_base + ADDR_W'(k3);
  end

  assign address = addr_q;

  // pixel shift register, LSB pixel first, 2 clocks each
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sr <= '0;
    else if (load) sr <= data;
    else if (xs[0]) sr <= sr >> nb;
  end

  // palette index from the low bpp bits of sr
  always_comb begin
    idx = {2'b00, sr[1:0]};
    case (mode_q)
      MODE_1BPP: idx = {3'b000, sr[0]};
      MODE_4BPP: idx = sr[3:0];
      default:   idx = {2'b00, sr[1:0]};
    endcase
  end

  // writable palette
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pal <= PAL_DEF;
    else if (pal_we) pal[pal_idx] <= pal_data;
  end

  // registered DAC and sync outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= shown ? pal[idx] : 12'h000;
      hs_q  <= hs_c;
      vs_q  <= vs_c;
    end
  end

  assign r  = rgb_q[11:8];
  assign g  = rgb_q[7:4];
  assign b  = rgb_q[3:0];
  assign hs = hs_q;
  assign vs = vs_q;

endmodule

// File: tb/tb_vcard_pix.sv
// Randomised scanout bench for vcard_pix against a frame-level model.
// Uses reduced vertical timing so several frames fit a short run.
module tb_vcard_pix;

  localparam int HV = 640, HF = 4, HS = 8, HB = 8;
  localparam int VV = 6, VF = 2, VS = 2, VB = 3;
  localparam int AW = 15;
  localparam int HW = HV + HF + HS + HB;
  localparam int VW = VV + VF + VS + VB;
  localparam int FR = HW * VW;
  localparam int PW = (VB + 1) * HW + HB + 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] r, g, b;
  logic hs, vs, irq;
  logic [AW-1:0] address;
  logic [7:0] data;
  logic [1:0] mode;
  logic [AW-1:0] base;
  logic pal_we;
  logic [3:0] pal_idx;
  logic [11:0] pal_data;

  vcard_pix #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
    .address(address), .data(data),
    .mode(mode), .base(base),
    .pal_we(pal_we), .pal_idx(pal_idx),
    .pal_data(pal_data), .irq(irq)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [32768];
  always @(posedge clock) data <= ram[address];

  int errors = 0;
  int checks = 0;
  logic [11:0] pal_m [16];
  logic [11:0] e4c [8];
  int pm [8];
  int pb [8];
  int f_mode, f_base;
  int p, run;
  bit pw_pend;
  int pw_idx;
  logic [11:0] pw_data;
  int hs_runs, hs_len, hs_bad, vs_hi;
  bit hs_prev;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h p=%0d",
             tag, obs, exp, p);
    end
  endtask

  function automatic int bpp_m(input int m);
    return (m == 0) ? 1 : ((m == 2) ? 4 : 2);
  endfunction

  // colour of raster position q from the logical framebuffer
  function automatic logic [11:0] exp_rgb(input int q);
    int x, y, xx, yy, nb, pp, ss, a, j, ix;
    x = q % HW; y = (q / HW) % VW;
    xx = x - HB; yy = y - VB;
    if (xx < 0 || xx >= HV || yy < 0 || yy >= VV)
      return 12'h000;
    nb = bpp_m(f_mode); pp = 16 / nb; ss = 40 * nb;
    a = (f_base + (yy / 2) * ss + xx / pp) % 32768;
    j = (xx % pp) / 2;
    ix = (int'(ram[a]) >> (j * nb)) & ((1 << nb) - 1);
    return pal_m[ix];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
    pal_m[0] = 12'h111; pal_m[1] = 12'hC0C;
    pal_m[2] = 12'h0CC; pal_m[3] = 12'hCCC;
    pw_pend = 0;
    f_mode = 1; f_base = 0;
    p = 0;
  endtask

  // check outputs for position p, then drive inputs for it
  task automatic eval_drive();
    int x, y, q, qx, qy, xf, nb, pp, ss, fr;
    x = p % HW; y = (p / HW) % VW; fr = p / FR;
    if (p == 0) begin
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_hs", hs, 1);
      chk("rst_vs", vs, 0);
      chk("rst_addr", address, 0);
    end else begin
      q = p - 1; qx = q % HW; qy = (q / HW) % VW;
      chk("rgb", {r, g, b}, exp_rgb(q));
      chk("hs", hs, (qx < HB + HV + HF) ? 1 : 0);
      chk("vs", vs, (qy >= VB + VV + VF) ? 1 : 0);
    end
`ifdef VCARD_IRQ_EN
    chk("irq", irq, (p > 0 && x == 0 && y == VB + VV) ? 1 : 0);
`else
    chk("irq", irq, 0);
`endif
    if (y >= VB && y < VB + VV) begin
      xf = x - HB + 2; nb = bpp_m(f_mode);
      pp = 16 / nb; ss = 40 * nb;
      if (xf >= 0 && xf % pp == 0 && xf / pp < ss)
        chk("fetch_addr", address,
            (f_base + ((y - VB) / 2) * ss + xf / pp) % 32768);
    end
    if (run == 0) begin
      for (int i = 0; i < 8; i++)
        if (p == VB * HW + HB + i + 1)
          chk("e4_pixel", {r, g, b}, e4c[i]);
      if (p == PW + 1) chk("palwr_old", {r, g, b}, 12'hC0C);
      if (p == PW + 2) chk("palwr_new", {r, g, b}, 12'hF00);
      if (p >= FR + 1 && p <= 2 * FR + 1) begin
        if (hs == 1'b0) hs_len++;
        else if (!hs_prev) begin
          hs_runs++;
          if (hs_len != HS) hs_bad++;
          hs_len = 0;
        end
        hs_prev = hs;
        if (vs && p <= 2 * FR) vs_hi++;
      end
      if (p == 2 * FR + 2) begin
        chk("hs_pulses", hs_runs, VW);
        chk("hs_width_bad", hs_bad, 0);
        chk("vs_clocks", vs_hi, VS * HW);
      end
    end
    if (pw_pend) begin
      pal_m[pw_idx] = pw_data;
      pw_pend = 0;
    end
    pal_we = 1'b0; pal_idx = '0; pal_data = '0;
    if (x == 0 && y == 0) begin
      mode = 2'(pm[fr % 8]);
      base = AW'(pb[fr % 8]);
      f_mode = int'(mode); f_base = int'(base);
    end else if (x == HW / 2 && y == VB + 2) begin
      mode = 2'($urandom);
      base = AW'($urandom);
    end
    if (run == 0 && p == PW) begin
      pal_we = 1'b1; pal_idx = 4'd1; pal_data = 12'hF00;
    end else if (fr >= 1 && $urandom_range(0, 49) == 0) begin
      pal_we = 1'b1;
      pal_idx = 4'($urandom);
      pal_data = 12'($urandom);
    end
    if (pal_we) begin
      pw_pend = 1; pw_idx = int'(pal_idx); pw_data = pal_data;
    end
  endtask

  task automatic run_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      p++;
      @(negedge clock);
      eval_drive();
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
    ram[0] = 8'hE4;
    e4c = '{12'h111, 12'h111, 12'hC0C, 12'hC0C,
            12'h0CC, 12'h0CC, 12'hCCC, 12'hCCC};
    pm[0] = 1; pb[0] = 0;
    pm[1] = 0; pb[1] = 100;
    pm[2] = 2; pb[2] = 32768 - 10;
    pm[3] = 3; pb[3] = int'($urandom_range(0, 32767));
    for (int i = 4; i < 8; i++) begin
      pm[i] = int'($urandom_range(0, 3));
      pb[i] = int'($urandom_range(0, 32767));
    end
    mode = 2'd0; base = '0;
    pal_we = 1'b0; pal_idx = '0; pal_data = '0;
    hs_runs = 0; hs_len = 0; hs_bad = 0; vs_hi = 0;
    hs_prev = 1'b1;
    run = 0;
    reset_model();

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("hold_rgb", {r, g, b}, 0);
    chk("hold_hs", hs, 1);
    chk("hold_vs", vs, 0);
    chk("hold_addr", address, 0);
    chk("hold_irq", irq, 0);

    reset_n = 1'b1;
    eval_drive();
    run_clocks(4 * FR + 5 * HW + 123);

    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rgb", {r, g, b}, 0);
    chk("midrst_hs", hs, 1);
    chk("midrst_vs", vs, 0);
    chk("midrst_addr", address, 0);
    chk("midrst_irq", irq, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run = 1;
    reset_model();
    eval_drive();
    run_clocks(FR + FR / 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
